// File: rtl/md5_arb_pkg.sv
// Shared constants and state encoding for the md5core requester arbiter.
package md5_arb_pkg;

    localparam int MSG_W = 448;
    localparam int LEN_W = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_IDLE  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/md5_core_arbiter_if.sv
// Requester-side bus of the md5core arbiter: message offer/grant plus result steering.
interface md5_core_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 3
);
    import md5_arb_pkg::*;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*MSG_W-1:0] req_msg;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       ret_valid;
    logic [TAG_W-1:0]         ret_tag;

    modport master (
        output req_valid, req_msg, req_len,
        input  req_ready, ret_valid, ret_tag
    );

    modport slave (
        input  req_valid, req_msg, req_len,
        output req_ready, ret_valid, ret_tag
    );

endinterface

// File: rtl/md5_core_arbiter_tag_fifo.sv
// First-word fall-through tag FIFO recording which requester owns each in-flight message.
module tag_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/md5_core_arbiter.sv
// Round-robin sharing of one pipelined md5core among NUM_REQ requesters, with drain handshake.
// Optional build macro MD5_ARB_STATS_EN adds issue and FIFO high-water counters.
module md5_core_arbiter
    import md5_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int TAG_W      = 3,
    parameter int FIFO_DEPTH = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    md5_core_arbiter_if.slave    req_if,
    output logic [MSG_W-1:0]     core_msg,
    output logic [LEN_W-1:0]     core_len,
    output logic                 core_valid,
    input  logic                 core_ret_valid,
    input  logic                 drain_req,
    output logic                 drain_done,
    output logic                 err_underflow,
    output logic [31:0]          stat_issued,
    output logic [TAG_W+7:0]     stat_hiwater
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [NUM_REQ-1:0] ONE_R  = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0] ZERO_R = {NUM_REQ{1'b0}};

    arb_state_e          state_r;
    logic [TAG_W-1:0]    ptr_r;
    logic [CNT_W-1:0]    fifo_count_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [TAG_W-1:0]    fifo_dout_s;
    logic [NUM_REQ-1:0]  lower_mask_s;
    logic [NUM_REQ-1:0]  valid_hi_s;
    logic [NUM_REQ-1:0]  pick_s;
    logic [NUM_REQ-1:0]  grant_s;
    logic                grant_fire_s;
    logic [TAG_W-1:0]    grant_idx_s;
    logic [TAG_W-1:0]    next_ptr_s;
    logic [MSG_W-1:0]    sel_msg_s;
    logic [LEN_W-1:0]    sel_len_s;
    logic                pop_hit_s;
    logic                drain_empty_s;
    logic [NUM_REQ-1:0]  ret_valid_s;

    tag_fifo #(.W(TAG_W), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (grant_fire_s),
        .pop   (core_ret_valid),
        .din   (grant_idx_s),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Round-robin pick: lowest valid at or above the pointer, else lowest valid overall.
    always_comb begin
        lower_mask_s = (ONE_R << ptr_r) - ONE_R;
        valid_hi_s   = req_if.req_valid & ~lower_mask_s;
        if (valid_hi_s != ZERO_R) begin
            pick_s = valid_hi_s;
        end else begin
            pick_s = req_if.req_valid;
        end
        if (state_r == ST_RUN && !fifo_full_s && !reset) begin
            grant_s = pick_s & (~pick_s + ONE_R);
        end else begin
            grant_s = ZERO_R;
        end
        grant_fire_s = |grant_s;
        grant_idx_s  = {TAG_W{1'b0}};
        sel_msg_s    = {MSG_W{1'b0}};
        sel_len_s    = {LEN_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                grant_idx_s = TAG_W'(i);
                sel_msg_s   = req_if.req_msg[i*MSG_W +: MSG_W];
                sel_len_s   = req_if.req_len[i*LEN_W +: LEN_W];
            end else begin
                grant_idx_s = grant_idx_s;
            end
        end
        if (grant_idx_s == TAG_W'(NUM_REQ - 1)) begin
            next_ptr_s = {TAG_W{1'b0}};
        end else begin
            next_ptr_s = grant_idx_s + {{(TAG_W-1){1'b0}}, 1'b1};
        end
    end

    // Result steering from the FIFO head; the drain check anticipates this cycle's pop.
    always_comb begin
        pop_hit_s     = core_ret_valid & ~fifo_empty_s & ~reset;
        drain_empty_s = fifo_empty_s | (core_ret_valid & (fifo_count_s == CNT_W'(1)));
        for (int i = 0; i < NUM_REQ; i++) begin
            ret_valid_s[i] = pop_hit_s & (fifo_dout_s == TAG_W'(i));
        end
    end

    assign req_if.req_ready = grant_s;
    assign req_if.ret_valid = ret_valid_s;
    assign req_if.ret_tag   = pop_hit_s ? fifo_dout_s : {TAG_W{1'b0}};

    // Issue register, round-robin pointer, underflow flag and drain state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_RUN;
            ptr_r         <= {TAG_W{1'b0}};
            core_valid    <= 1'b0;
            core_msg      <= {MSG_W{1'b0}};
            core_len      <= {LEN_W{1'b0}};
            drain_done    <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            core_valid <= grant_fire_s;
            if (grant_fire_s) begin
                core_msg <= sel_msg_s;
                core_len <= sel_len_s;
                ptr_r    <= next_ptr_s;
            end
            if (core_ret_valid && fifo_empty_s) begin
                err_underflow <= 1'b1;
            end
            case (state_r)
                ST_RUN: begin
                    if (drain_req) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!drain_req) begin
                        state_r <= ST_RUN;
                    end else if (drain_empty_s) begin
                        state_r    <= ST_IDLE;
                        drain_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (!drain_req) begin
                        state_r    <= ST_RUN;
                        drain_done <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_RUN;
                    drain_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef MD5_ARB_STATS_EN
    logic [31:0]      issued_r;
    logic [TAG_W+7:0] hiwater_r;

    // Saturating issue counter and peak registered FIFO occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            issued_r  <= 32'd0;
            hiwater_r <= {(TAG_W+8){1'b0}};
        end else begin
            if (core_valid && issued_r != 32'hFFFF_FFFF) begin
                issued_r <= issued_r + 32'd1;
            end
            if ((TAG_W+8)'(fifo_count_s) > hiwater_r) begin
                hiwater_r <= (TAG_W+8)'(fifo_count_s);
            end
        end
    end

    assign stat_issued  = issued_r;
    assign stat_hiwater = hiwater_r;
`else
    assign stat_issued  = 32'd0;
    assign stat_hiwater = {(TAG_W+8){1'b0}};
`endif

endmodule
